// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared types and constants for the key debounce scheduler
// Purpose: FSM state encoding, press-counter width and key polarity.
// Ports: none (package).
package key_pkg;

  typedef enum logic [1:0] {
    SCAN = 2'd0,
    LOCK = 2'd1,
    EMIT = 2'd2
  } state_t;

  localparam int   CNT_W      = 10;
  // Keys are active-low: idle level is 1, pressed level is 0.
  localparam logic KEY_ACTIVE = 1'b0;
  localparam logic KEY_IDLE   = 1'b1;

endpackage

// File: rtl/key_sync2.sv
// rtl/key_sync2.sv - parameterized-width two-flop synchronizer, resets to idle (1)
// Purpose: bring the asynchronous raw key vector into the clk domain.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset, flops go to 1
//   d    - asynchronous input vector
//   q    - synchronized output vector
module key_sync2 #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_debounce_sched.sv
// rtl/key_debounce_sched.sv - shared-engine round-robin key debouncer with event handshake
// Purpose: one debounce counter time-multiplexed over N_KEYS active-low keys;
//   publishes debounced levels and press/release events over valid/ready.
// Optional feature: KEY_PRESS_CNT_EN adds the `count` press counter port.
// Ports:
//   clk        - system clock, rising edge
//   rst        - synchronous active-high reset
//   key_raw    - asynchronous raw keys, active-low
//   key_level  - debounced levels, same polarity as key_raw
//   evt_valid  - event pending
//   evt_ready  - consumer accepts event when high with evt_valid
//   evt_idx    - key index of the pending event
//   evt_press  - 1 = press (1->0), 0 = release (0->1)
//   busy       - high whenever the FSM is not scanning
//   count      - accepted press events, wraps (KEY_PRESS_CNT_EN only)
module key_debounce_sched
  import key_pkg::*;
#(
  parameter int N_KEYS = 4,
  parameter int DB_CYC = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_KEYS-1:0]         key_raw,
  output logic [N_KEYS-1:0]         key_level,
  output logic                      evt_valid,
  input  logic                      evt_ready,
  output logic [$clog2(N_KEYS)-1:0] evt_idx,
  output logic                      evt_press,
  output logic                      busy
`ifdef KEY_PRESS_CNT_EN
  ,
  output logic [CNT_W-1:0]          count
`endif
);

  localparam int IDX_W = $clog2(N_KEYS);
  localparam int DB_W  = $clog2(DB_CYC + 1);

  state_t            state;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  ptr_nxt;
  logic [DB_W-1:0]   cnt;
  logic [DB_W-1:0]   cnt_inc;
  logic [N_KEYS-1:0] s;
  logic              differs;

  key_sync2 #(.W(N_KEYS)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (key_raw),
    .q   (s)
  );

  assign differs = (s[ptr] != key_level[ptr]);
  assign ptr_nxt = (ptr == IDX_W'(N_KEYS - 1)) ? '0 : ptr + 1'b1;
  assign cnt_inc = cnt + 1'b1;
  assign busy    = (state != SCAN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SCAN;
      ptr       <= '0;
      cnt       <= '0;
      key_level <= {N_KEYS{KEY_IDLE}};
      evt_valid <= 1'b0;
      evt_idx   <= '0;
      evt_press <= 1'b0;
    end else begin
      case (state)
        SCAN: begin
          if (differs) begin
            state <= LOCK;
            cnt   <= '0;
          end else begin
            ptr <= ptr_nxt;
          end
        end
        LOCK: begin
          if (differs) begin
            cnt <= cnt_inc;
            if (cnt_inc == DB_W'(DB_CYC)) begin
              // s[ptr] differs from the current level, so taking it is a toggle.
              key_level[ptr] <= s[ptr];
              evt_valid      <= 1'b1;
              evt_idx        <= ptr;
              evt_press      <= (s[ptr] == KEY_ACTIVE);
              state          <= EMIT;
            end
          end else begin
            // Bounce: give up on this key and move on so others are not starved.
            state <= SCAN;
            ptr   <= ptr_nxt;
          end
        end
        EMIT: begin
          // Scanner stays parked here under backpressure; nothing else updates.
          if (evt_ready) begin
            evt_valid <= 1'b0;
            state     <= SCAN;
            ptr       <= ptr_nxt;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

`ifdef KEY_PRESS_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (evt_valid && evt_ready && evt_press) begin
      count <= count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_key_debounce_sched.sv
// tb/tb_key_debounce_sched.sv - scoreboard bench for key_debounce_sched
module tb_key_debounce_sched;

  localparam int N_KEYS = 4;
  localparam int DB_CYC = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_raw;
  logic [3:0] key_level;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_idx;
  logic       evt_press;
  logic       busy;
`ifdef KEY_PRESS_CNT_EN
  logic [9:0] count;
`endif

  typedef struct packed {
    logic [1:0] idx;
    logic       press;
  } evt_t;

  evt_t exp_q[$];
  evt_t got_e;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   acc_cyc0 = 0;
  logic       hold_v = 1'b0;
  logic [1:0] hold_idx;
  logic       hold_press;

  always #5 clk = ~clk;

  key_debounce_sched #(.N_KEYS(N_KEYS), .DB_CYC(DB_CYC)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_raw   (key_raw),
    .key_level (key_level),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_idx   (evt_idx),
    .evt_press (evt_press),
    .busy      (busy)
`ifdef KEY_PRESS_CNT_EN
    ,
    .count     (count)
`endif
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int idx, input bit press);
    evt_t e;
    e.idx   = 2'(idx);
    e.press = press;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || evt_valid) && n < budget) begin
      tick();
      n++;
    end
    chk(tag, exp_q.size(), 0);
    tick();
    tick();
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!evt_valid && n < budget);
  endtask

  task automatic do_reset;
    rst     = 1'b1;
    key_raw = 4'hF;
    repeat (3) tick();
  endtask

  // Monitor: pops the scoreboard on every handshake and checks stall stability.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("stall_valid", int'(evt_valid), 1);
        chk("stall_idx", int'(evt_idx), int'(hold_idx));
        chk("stall_press", int'(evt_press), int'(hold_press));
      end
      if (evt_valid && evt_ready) begin
        chk("evt_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          got_e = exp_q.pop_front();
          chk("evt_idx", int'(evt_idx), int'(got_e.idx));
          chk("evt_press", int'(evt_press), int'(got_e.press));
        end
        if (evt_idx == 2'd0) acc_cyc0 = cyc;
      end
      hold_v     = evt_valid && !evt_ready;
      hold_idx   = evt_idx;
      hold_press = evt_press;
    end
  end

  initial begin
    int n;
    int t3;
    evt_ready = 1'b1;
    do_reset();
    chk("rst_level", int'(key_level), 15);
    chk("rst_valid", int'(evt_valid), 0);
    chk("rst_busy", int'(busy), 0);
`ifdef KEY_PRESS_CNT_EN
    chk("rst_count", int'(count), 0);
`endif

    // Clean press on key 2 right after reset: ptr reaches 2 exactly at detection.
    rst        = 1'b0;
    key_raw[2] = 1'b0;
    push(2, 1'b1);
    wait_valid(60, n);
    chk("press_latency", n, DB_CYC + 3);
    chk("press_idx", int'(evt_idx), 2);
    chk("press_dir", int'(evt_press), 1);
    drain("press_drain", 20);
    chk("press_level", int'(key_level), 4'b1011);
`ifdef KEY_PRESS_CNT_EN
    chk("press_count", int'(count), 1);
`endif
    key_raw[2] = 1'b1;
    push(2, 1'b0);
    drain("release_drain", 60);
    chk("release_level", int'(key_level), 15);
`ifdef KEY_PRESS_CNT_EN
    chk("release_count", int'(count), 1);
`endif

    // Bounce on key 0, then a solid press.
    for (int i = 0; i < 20; i++) begin
      key_raw[0] = ~key_raw[0];
      tick();
      chk("bounce_no_evt", int'(evt_valid), 0);
    end
    key_raw[0] = 1'b0;
    push(0, 1'b1);
    repeat (30) tick();
    chk("bounce_one_evt", exp_q.size(), 0);
    chk("bounce_level", int'(key_level[0]), 0);
    key_raw[0] = 1'b1;
    push(0, 1'b0);
    drain("bounce_rel_drain", 60);

    // Glitch shorter than DB_CYC on key 1.
    key_raw[1] = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i == 10) key_raw[1] = 1'b1;
      tick();
      chk("glitch_level", int'(key_level[1]), 1);
      chk("glitch_no_evt", int'(evt_valid), 0);
    end

    // Backpressure: keys 0 and 3 together, timed so key 0 is scanned first.
    do_reset();
    rst       = 1'b0;
    evt_ready = 1'b0;
    acc_cyc0  = 0;
    tick();
    tick();
    key_raw = 4'b0110;
    push(0, 1'b1);
    push(3, 1'b1);
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("bp_key3_level", int'(key_level[3]), 1);
    end
    chk("bp_valid", int'(evt_valid), 1);
    chk("bp_idx", int'(evt_idx), 0);
    evt_ready = 1'b1;
    t3 = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (evt_valid && evt_idx == 2'd3) begin
        t3 = cyc;
        break;
      end
    end
    chk("bp_key3_seen", int'(t3 != 0), 1);
    chk("bp_gap_ge", int'((t3 - acc_cyc0) >= DB_CYC + 1), 1);
    drain("bp_drain", 20);
`ifdef KEY_PRESS_CNT_EN
    chk("bp_count", int'(count), 2);
`endif

    // Reset while key 1 is in LOCK.
    do_reset();
    rst        = 1'b0;
    key_raw[1] = 1'b0;
    n = 0;
    while (!busy && n < 20) begin
      tick();
      n++;
    end
    chk("mid_lock_entered", int'(busy), 1);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    chk("mid_busy", int'(busy), 0);
    chk("mid_valid", int'(evt_valid), 0);
    chk("mid_level", int'(key_level), 15);
    rst = 1'b0;
    push(1, 1'b1);
    wait_valid(60, n);
    // ptr restarts at 0, so key 1 is re-detected at the sixth edge after release.
    chk("mid_relatency", n, DB_CYC + 6);
    drain("mid_drain", 20);
    key_raw[1] = 1'b1;
    push(1, 1'b0);
    drain("mid_rel_drain", 60);

    chk("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_debounce_sched.md
# key_debounce_sched

Shared-engine debouncer and event scheduler for a bank of mechanical keys. A round-robin scanner time-multiplexes one debounce counter across `N_KEYS` raw inputs. It publishes a stable per-key level and emits press/release events over a valid/ready handshake to downstream logic (LED control, menu FSM). It replaces per-key debounce counters when the key count grows.

## Interface
- `N_KEYS`, 4: number of raw key inputs (2..16).
- `DB_CYC`, 16: consecutive stable samples required to accept a level change (2..1023).
- `clk` in 1: single system clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `key_raw` in N_KEYS: asynchronous raw keys, active-low (idle 1, pressed 0).
- `key_level` out N_KEYS: debounced levels, same polarity as `key_raw`.
- `evt_valid` out 1: event pending.
- `evt_ready` in 1: consumer accepts the event when high with `evt_valid`.
- `evt_idx` out clog2(N_KEYS): key index of the event.
- `evt_press` out 1: 1 = press (1→0), 0 = release (0→1).
- `busy` out 1: high whenever the FSM is not in SCAN.
- `count` out 10: press count. Present only with `KEY_PRESS_CNT_EN`.

## Operation
- Each `key_raw` bit passes through a 2-flop synchronizer. Synchronizer flops reset to 1. The synchronized vector is `s`.
- Scan pointer `ptr` runs 0..N_KEYS-1 and wraps to 0.
- Debounce counter `cnt` is clog2(DB_CYC+1) bits wide.
- FSM states:
  - SCAN: if `s[ptr] != key_level[ptr]`, go to LOCK with `cnt`=0. Otherwise `ptr`++.
  - LOCK: if `s[ptr] != key_level[ptr]`, `cnt`++. When the incremented value equals DB_CYC, toggle `key_level[ptr]`, load the event registers and go to EMIT.
  - LOCK bounce: if `s[ptr] == key_level[ptr]`, abort to SCAN with `ptr`++. This gives fairness: a bouncing key cannot starve the others.
  - EMIT: `evt_valid`=1 with `evt_idx`=`ptr` and `evt_press`=new level==0. On `evt_valid & evt_ready`, go to SCAN with `ptr`++.
- Outputs are stable while `evt_valid` is high and not yet accepted.
- Downstream backpressure stalls the scanner. No event is ever dropped, and other keys' levels are not updated during the stall.
- Only the key under `ptr` can change level, so at most one `key_level` bit changes per cycle.
- Reset values:
  - `key_level` all 1.
  - `evt_valid`, `evt_idx`, `evt_press`, `busy` = 0.
  - `ptr`, `cnt` = 0; state SCAN.
  - `count` = 0.
- `rst` mid-LOCK or mid-EMIT aborts immediately. A pending event is discarded and the levels return to 1.
- A raw change shorter than DB_CYC samples is ignored entirely: no level change, no event.

## Timing
- Best-case latency: `key_level` and `evt_valid` update on the (DB_CYC+3)-th rising edge, counting the edge that first samples the new raw value. This assumes `ptr` already points at the key and no bounce occurs. Breakdown: 2 sync edges, 1 SCAN detect edge, DB_CYC LOCK edges.
- Worst-case extra scan wait, no stalls: N_KEYS−1 cycles.
- Handshake completes on the accepting edge. `evt_valid` deasserts the next cycle. Back-to-back events are therefore separated by at least DB_CYC+1 cycles.
- `evt_ready` may be held high permanently. `evt_ready` has no combinational path to any output.

## Configuration
- `KEY_PRESS_CNT_EN` defined:
  - The `count` port exists.
  - It increments by 1 on every accepted event with `evt_press`=1.
  - It wraps 1023→0 and resets to 0.
- Not defined: the `count` port and its register are absent. All other behaviour is identical.

## Structure
- Shared package `key_pkg`: FSM state enum {SCAN, LOCK, EMIT}, the `CNT_W`=10 constant, and the active-low key polarity constant.
- One sub-module `key_sync2`: a parameterized-width 2-flop synchronizer with reset value 1, instantiated once over the whole `key_raw` vector.
- FSM, pointer, counter and event registers live in the top module.

## Test plan
- Reset: hold `rst` for 3 cycles with `key_raw`=4'b1111. Required: `key_level`=4'b1111, `evt_valid`=0, `count`=0, `busy`=0.
- Clean press on key 2, DB_CYC=16, `evt_ready`=1. Required: `evt_valid` high on edge 19 with `evt_idx`=2 and `evt_press`=1; `count`=1 after acceptance. Releasing key 2 gives an event with `evt_press`=0 and leaves `count` unchanged.
- Bounce: 20 toggles of key 0 at 1-cycle spacing, then held 0 for 30 cycles. Required: exactly one press event for key 0, and no event during the bounce.
- Glitch: key 1 low for 10 cycles, then high. Required: no event and `key_level[1]`=1 throughout.
- Backpressure: press keys 0 and 3 together with `evt_ready`=0 for 50 cycles, then `evt_ready`=1. Required:
  - The key 0 event is held stable for the whole stall.
  - Key 3's event follows after ≥DB_CYC+1 cycles.
  - `count`=2.
- Mid-operation reset: assert `rst` while in LOCK for key 1. Required: FSM in SCAN, `ptr`=0, no event. The key is re-debounced from scratch after release of `rst`.
